// File: rtl/imem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : imem_loader
// Brief  : Boot loader that parses a framed byte stream (SYNC, LEN_LO, LEN_HI,
//          4*N little-endian data bytes, XOR checksum), writes each word into
//          instruction memory and holds the CPU in reset until a good image.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_address,
  output logic [31:0] imem_data_in,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  // One extra bit so an index equal to MAX_WORDS is representable.
  localparam int          IDX_W   = $clog2(MAX_WORDS) + 1;
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CHK   = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        len_lo;
  logic [IDX_W-1:0]  len_words;
  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        byte_cnt;
  logic [7:0]        checksum;
  logic [23:0]       word_buf;   // lower three bytes of the word in progress

  logic              fire;
  logic              is_sync;
  logic [15:0]       len_full;
  logic              last_word;

  assign fire      = byte_valid && byte_ready;
  assign is_sync   = (byte_data == SYNC_BYTE);
  assign len_full  = {byte_data, len_lo};
  assign last_word = ((word_idx + IDX_W'(1)) == len_words);

  // Status outputs are pure decodes of the state register.
  assign byte_ready = (state != S_WRITE);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERROR);
  assign cpu_reset  = (state != S_DONE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; every state holds when no byte is transferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (fire && is_sync) state_next = S_LEN0;
      S_LEN0:  if (fire) state_next = S_LEN1;
      S_LEN1: begin
        if (fire) begin
          if ({1'b0, len_full} > MAX_LEN) state_next = S_ERROR;
          else if (len_full == 16'd0)     state_next = S_CHK;
          else                            state_next = S_DATA;
        end
      end
      S_DATA:  if (fire && (byte_cnt == 2'd3)) state_next = S_WRITE;
      S_WRITE: state_next = last_word ? S_CHK : S_DATA;
      S_CHK:   if (fire) state_next = (byte_data == checksum) ? S_DONE : S_ERROR;
      S_DONE:  if (fire && is_sync) state_next = S_LEN0;
      S_ERROR: if (fire && is_sync) state_next = S_LEN0;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: length latch, word assembly, checksum, write strobe and address.
  always_ff @(posedge clock) begin
    if (reset) begin
      imem_we      <= 1'b0;
      imem_address <= BASE_ADDR;
      imem_data_in <= 32'h0;
      len_lo       <= 8'h0;
      len_words    <= '0;
      word_idx     <= '0;
      byte_cnt     <= 2'd0;
      checksum     <= 8'h0;
      word_buf     <= 24'h0;
    end else begin
      // Strobe is high for exactly the cycle spent in WRITE.
      imem_we <= (state_next == S_WRITE);
      if (fire) begin
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (is_sync) begin
              word_idx <= '0;
              byte_cnt <= 2'd0;
              checksum <= 8'h0;
            end
          end
          S_LEN0: len_lo <= byte_data;
          // Only in-range lengths are used, so truncation is safe.
          S_LEN1: len_words <= len_full[IDX_W-1:0];
          S_DATA: begin
            checksum <= checksum ^ byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= byte_data;
              2'd1: word_buf[15:8]  <= byte_data;
              2'd2: word_buf[23:16] <= byte_data;
              default: begin
                imem_data_in <= {byte_data, word_buf};
                imem_address <= BASE_ADDR + (32'(word_idx) << 2);
              end
            endcase
          end
          default: ;
        endcase
      end
      if (state == S_WRITE) word_idx <= word_idx + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_imem_loader
// Brief  : Self-checking bench for imem_loader; directed frames plus random
//          frames compared against a frame-level reference model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 1024;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_address;
  logic [31:0] imem_data_in;
  logic        cpu_reset;
  logic        done;
  logic        error;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .SYNC_BYTE(SYNC)) dut (
    .clock        (clk),
    .reset        (rst),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_address (imem_address),
    .imem_data_in (imem_data_in),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int gap_mode = 0;   // 0 back-to-back, 1 one idle cycle per byte, 2 random gaps

  logic [7:0]  frame_q[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic        obs_rdy[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done;
  logic        exp_err;

  // Record every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      obs_addr.push_back(imem_address);
      obs_data.push_back(imem_data_in);
      obs_rdy.push_back(byte_ready);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    if (gap_mode == 1) tick();
    else if (gap_mode == 2) repeat ($urandom_range(0, 2)) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && waited < 16) begin
      tick();
      waited++;
    end
    if (waited >= 16) check("ready_timeout", {31'b0, byte_ready}, 32'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  // Frame-level reference: find the sync byte, read the length, slice the
  // data into little-endian words, XOR all data bytes, compare with CHK.
  task automatic model();
    int p = 0;
    int n;
    logic [7:0]  chk = 8'h00;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    while (p < frame_q.size() && frame_q[p] != SYNC) p++;
    n = int'({frame_q[p+2], frame_q[p+1]});
    if (n > MAXW) begin
      exp_err  = 1'b1;
      exp_done = 1'b0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {frame_q[p+6+4*i], frame_q[p+5+4*i], frame_q[p+4+4*i], frame_q[p+3+4*i]};
      chk = chk ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      exp_addr.push_back(BASE + 32'(4 * i));
      exp_data.push_back(w);
    end
    exp_done = (frame_q[p+3+4*n] == chk);
    exp_err  = !exp_done;
  endtask

  task automatic build_frame(input int n, input bit bad, input int garbage);
    logic [7:0] d;
    logic [7:0] chk = 8'h00;
    frame_q.delete();
    repeat (garbage) begin
      d = 8'($urandom_range(0, 255));
      if (d == SYNC) d = 8'h00;
      frame_q.push_back(d);
    end
    frame_q.push_back(SYNC);
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    if (n <= MAXW) begin
      repeat (4 * n) begin
        d = 8'($urandom_range(0, 255));
        chk = chk ^ d;
        frame_q.push_back(d);
      end
      if (bad) chk = chk ^ (8'h01 << $urandom_range(0, 7));
      frame_q.push_back(chk);
    end
  endtask

  task automatic run_frame(input string tag);
    int m;
    model();
    obs_addr.delete();
    obs_data.delete();
    obs_rdy.delete();
    foreach (frame_q[i]) send_byte(frame_q[i]);
    repeat (2) tick();
    check({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      check({tag, "_addr"}, obs_addr[i], exp_addr[i]);
      check({tag, "_data"}, obs_data[i], exp_data[i]);
      check({tag, "_ready_in_write"}, {31'b0, obs_rdy[i]}, 32'd0);
    end
    check({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
    check({tag, "_error"}, {31'b0, error}, {31'b0, exp_err});
    check({tag, "_cpu_reset"}, {31'b0, cpu_reset}, {31'b0, !exp_done});
    check({tag, "_we_idle"}, {31'b0, imem_we}, 32'd0);
    if (exp_addr.size() > 0) begin
      check({tag, "_addr_hold"}, imem_address, exp_addr[exp_addr.size()-1]);
      check({tag, "_data_hold"}, imem_data_in, exp_data[exp_data.size()-1]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {31'b0, byte_ready}, 32'd1);
    check({tag, "_we"}, {31'b0, imem_we}, 32'd0);
    check({tag, "_addr"}, imem_address, BASE);
    check({tag, "_data"}, imem_data_in, 32'h0);
    check({tag, "_cpu_reset"}, {31'b0, cpu_reset}, 32'd1);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_error"}, {31'b0, error}, 32'd0);
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    check_reset_values("rst");
    rst = 1'b0;
    tick();

    // Test 1: two-word image with a good checksum
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    run_frame("t1");
    if (obs_data.size() == 2) begin
      check("t1_word0_const", obs_data[0], 32'h0010_0513);
      check("t1_word1_const", obs_data[1], 32'h0020_0593);
      check("t1_addr1_const", obs_addr[1], 32'h0000_0004);
    end

    // Test 2: same image with a corrupted checksum
    frame_q[11] = 8'h00;
    run_frame("t2");

    // Test 3: leading garbage and byte_valid toggling every other cycle
    frame_q = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10,
                8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    gap_mode = 1;
    run_frame("t3");
    gap_mode = 0;

    // Test 4: length one past the maximum is rejected immediately
    obs_addr.delete();
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h04);
    check("t4_error_after_len", {31'b0, error}, 32'd1);
    repeat (3) tick();
    check("t4_no_writes", 32'(obs_addr.size()), 32'd0);
    check("t4_cpu_reset", {31'b0, cpu_reset}, 32'd1);

    // Test 5: reset in the middle of the data phase, then a clean 1-word frame
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    tick();
    check_reset_values("t5_rst");
    rst = 1'b0;
    build_frame(1, 1'b0, 0);
    run_frame("t5");

    // Test 6: restart from DONE, then a zero-length image
    obs_addr.delete();
    send_byte(SYNC);
    check("t6_cpu_reset_restart", {31'b0, cpu_reset}, 32'd1);
    check("t6_done_restart", {31'b0, done}, 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (2) tick();
    check("t6_done_zero_len", {31'b0, done}, 32'd1);
    check("t6_no_writes", 32'(obs_addr.size()), 32'd0);

    // Zero-length image with a nonzero checksum
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h01};
    run_frame("zero_bad");

    // Largest accepted image
    build_frame(MAXW, 1'b0, 0);
    run_frame("max_len");

    // Random frames with garbage, gaps and occasional bad checksums/lengths
    gap_mode = 2;
    for (int k = 0; k < 25; k++) begin
      if (k % 8 == 7) build_frame(MAXW + 1 + int'($urandom_range(0, 100)), 1'b0, int'($urandom_range(0, 3)));
      else build_frame(int'($urandom_range(1, 6)), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
      run_frame("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
